// File: rtl/muldiv_unit_if.sv
// Handshake and result bus between the execute stage and the
// iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divbyzero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, divbyzero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, divbyzero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
// Operations:
// - MULT/MULTU use shift-add.
// - DIV/DIVU use restoring division.
// - Each runs one step per cycle, and a result takes WIDTH+1 cycles.
//
// Signed handling:
// - Signed ops run on operand magnitudes.
// - The sign is fixed up in the final cycle.
//
// MTHI/MTLO write HI/LO directly from IDLE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  muldiv_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Two's-complement magnitude.
  // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      magnitude = (~v) + ONE_W;
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
    negate_w = (~v) + ONE_W;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Accumulator layout:
  // - MUL: {partial product high, remaining multiplier bits}.
  // - DIV: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand for MUL, divisor for DIV (always a magnitude).
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;   // negate product / quotient
  logic                 neg_rem_q, neg_rem_d;   // negate remainder
  logic                 dz_q, dz_d;             // divisor was zero
  logic [WIDTH-1:0]     araw_q, araw_d;         // dividend as presented
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH:0]       add_s;
  logic [2*WIDTH-1:0]   mul_step_s;
  logic [WIDTH:0]       rem_sh_s;
  logic                 ge_s;
  logic [WIDTH-1:0]     rem_nx_s;
  logic [2*WIDTH-1:0]   div_step_s;
  logic [2*WIDTH-1:0]   prod_s;

  // Operand magnitudes; signed handling only for the odd opcodes.
  always_comb begin
    a_mag_s = magnitude(bus.a, bus.op[0]);
    b_mag_s = magnitude(bus.b, bus.op[0]);
  end

  // One shift-add and one restoring-division step, plus the signed product fix-up.
  always_comb begin
    add_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_step_s = {add_s, acc_q[WIDTH-1:1]};

    rem_sh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge_s       = (rem_sh_s >= {1'b0, opnd_q});
    rem_nx_s   = WIDTH'(ge_s ? (rem_sh_s - {1'b0, opnd_q}) : rem_sh_s);
    div_step_s = {rem_nx_s, acc_q[WIDTH-2:0], ge_s};

    prod_s     = neg_res_q ? ((~acc_q) + ONE_2W) : acc_q;
  end

  // Next-state and output logic for IDLE/ITER/FIN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    araw_d    = araw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d  = bus.op[1];
              neg_res_d = bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_rem_d = bus.op[0] & bus.a[WIDTH-1];
              if (bus.op[1]) begin
                acc_d  = {ZERO_W, a_mag_s};
                opnd_d = b_mag_s;
              end else begin
                acc_d  = {ZERO_W, b_mag_s};
                opnd_d = a_mag_s;
              end
              dz_d    = bus.op[1] & (bus.b == ZERO_W);
              araw_d  = bus.a;
              cnt_d   = CNT_W'(WIDTH);
              dbz_d   = 1'b0;
              busy_d  = 1'b1;
              state_d = S_ITER;
            end
            3'b100:  hi_d = bus.a;
            3'b101:  lo_d = bus.a;
            default: hi_d = hi_q;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ITER: begin
        acc_d = is_div_q ? div_step_s : mul_step_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_ITER;
        end
      end

      S_FIN: begin
        if (dz_q) begin
          hi_d  = araw_q;
          lo_d  = {WIDTH{1'b1}};
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_res_q ? negate_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? negate_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      opnd_q    <= ZERO_W;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      araw_q    <= ZERO_W;
      hi_q      <= ZERO_W;
      lo_q      <= ZERO_W;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      araw_q    <= araw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.divbyzero = dbz_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core, replacing the combinational mulu/divu path in the ALU. It executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles using a start/busy/done handshake, and handles MTHI/MTLO writes. The unit sits beside the ALU in the execute stage. The datapath reads `hi`/`lo` directly for mfhi/mflo, and the controller stalls the PC while `busy` is high.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, others are a no-op.
- a  in  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO data.
- b  in  WIDTH  operand B: multiplier or divisor.
- busy  out  1  high while an iterative op is in flight.
- done  out  1  one-cycle pulse when HI/LO take a new mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- divbyzero  out  1  sticky flag, set by DIV/DIVU with b==0; cleared at the next accepted start.

## Operation
- States: IDLE, ITER, FIN.
- Reset value of every output is 0: hi, lo, busy, done, divbyzero. The state returns to IDLE.

IDLE with start=1:
- Mul/div op:
  - Latch the operands.
  - For the signed ops, latch the magnitudes plus sign bits: sign_q = a[W-1]^b[W-1], sign_r = a[W-1].
  - Clear divbyzero, load the iteration counter with WIDTH, go to ITER.
- MTHI/MTLO: write a into hi or lo at that edge. State stays IDLE; busy and done stay 0.
- Reserved op: ignored.

ITER (one step per cycle, counter decrements, leave to FIN when the counter reaches 0 after WIDTH steps):
- MUL: shift-add on a 2·WIDTH accumulator. Each cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper half.
  - Shift the accumulator right by 1, keeping the carry.
- DIV: restoring division. Each cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem.
  - If the result is non-negative, keep it and set the quo LSB to 1.

FIN (one cycle):
- Apply the sign correction for the signed ops:
  - product negated if sign_q;
  - quotient negated if sign_q;
  - remainder negated if sign_r.
- Write hi (upper product half or remainder) and lo (lower half or quotient).
- Pulse done, go to IDLE.

Boundary cases:
- Divide by zero, either op:
  - Takes the full latency.
  - hi = a as presented; lo = all ones.
  - divbyzero = 1 from the FIN edge onward.
- DIV of most-negative by −1: lo = most-negative, hi = 0, no flag. This follows naturally from magnitude arithmetic.
- Signed magnitude of the most-negative value is 2^(W-1), which must be represented correctly in WIDTH bits unsigned.
- hi/lo keep their previous values during ITER; they are only written in FIN or by MTHI/MTLO.
- start while busy (ITER/FIN): ignored. No queuing, no effect on the in-flight op.
- Reset mid-operation: aborts next edge. All outputs return to 0 and the partial result is discarded.

## Timing
- Accept edge E0 (IDLE, start=1, mul/div op).
- busy = 1 from after E0 through the cycle ending at E(WIDTH+1).
- hi/lo/done update at E(WIDTH+1).
- done is high exactly one cycle.
- busy = 0 in the same cycle that done = 1, so a new start can be accepted on the edge that ends the done cycle.
- Latency: WIDTH+1 cycles. With WIDTH=32, the result is visible 33 cycles after the accept edge.
- MTHI/MTLO: hi/lo visible the cycle after the accept edge. No stall.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF (W=32):
  - hi=0xFFFFFFFE, lo=0x00000001;
  - done exactly 33 cycles after accept;
  - busy high for 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIVU 100/7 → lo=14, hi=2. DIV 0xFFFFFFF9 (−7)/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, divbyzero=0.
- DIVU 5/0:
  - hi=5, lo=0xFFFFFFFF, divbyzero=1;
  - the next accepted MULTU clears divbyzero at its accept edge.
- MTHI a=0x1234 in IDLE → hi=0x1234 next cycle, busy/done stay 0. MTLO issued while busy → ignored, lo unchanged.
- Reset asserted at the 10th ITER cycle → next cycle busy=0, done=0, hi=lo=0; no done pulse follows. A start pulse mid-op without reset → ignored, the original result is unaffected.
